// File: rtl/finger_motion_sequencer.sv
// Gesture-driven sequencer for five finger servos: it looks up per-finger target widths,
// ramps the widths toward them at a bounded rate per tick, then settles before reporting done.
//
// state | meaning
// IDLE  | waiting for a gesture request; widths hold their last values
// LOAD  | register the clamped per-finger targets for the accepted code
// RAMP  | step every width toward its target on each tick
// HOLD  | settle for HOLD_TICKS ticks, then pulse done
module finger_motion_sequencer #(
    parameter int TICK_CYCLES = 50000,
    parameter int STEP_US     = 10,
    parameter int HOLD_TICKS  = 20,
    parameter int MIN_US      = 1000,
    parameter int MAX_US      = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  gesture,
    input  logic        gesture_valid,
    output logic        gesture_ready,
    input  logic        abort,
    output logic [15:0] width_thumb,
    output logic [15:0] width_index,
    output logic [15:0] width_middle,
    output logic [15:0] width_ring,
    output logic [15:0] width_pinky,
    output logic        busy,
    output logic        done,
    output logic        unknown
);

    typedef enum logic [1:0] {IDLE, LOAD, RAMP, HOLD} state_t;

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);
    localparam logic [15:0] RESET_US = 16'd1500;
    localparam logic signed [16:0] STEP_S = 17'(STEP_US);

    state_t state, state_nx;
    logic [PW-1:0] presc;
    logic [HW-1:0] hold_cnt;
    logic [7:0]    gesture_q;
    logic          tick;
    logic          accept;
    logic          all_at;
    logic          done_nx;
    logic          tbl_unknown;
    int            tbl_raw [5];
    logic [15:0]   tbl_us  [5];
    logic [15:0]   width   [5];
    logic [15:0]   target  [5];
    logic [15:0]   width_nx [5];
    logic signed [16:0] diff [5];

    function automatic logic [15:0] clamp_us(input int v);
        if (v < MIN_US) return 16'(MIN_US);
        if (v > MAX_US) return 16'(MAX_US);
        return 16'(v);
    endfunction

    assign tick   = (presc == PRESC_LAST);
    assign accept = gesture_valid && gesture_ready;

    // Finger order: 0 thumb, 1 index, 2 middle, 3 ring, 4 pinky.
    always_comb begin
        tbl_unknown = 1'b0;
        for (int i = 0; i < 5; i++) tbl_raw[i] = 1500;
        case (gesture_q)
            8'h01: for (int i = 0; i < 5; i++) tbl_raw[i] = 1500;
            8'h02: for (int i = 0; i < 5; i++) tbl_raw[i] = 1400;
            8'h03: for (int i = 0; i < 5; i++) tbl_raw[i] = 1000;
            8'h04: for (int i = 0; i < 5; i++) tbl_raw[i] = 2000;
            8'h05: begin
                for (int i = 0; i < 5; i++) tbl_raw[i] = 2000;
                tbl_raw[1] = 1000;
            end
            default: tbl_unknown = 1'b1;
        endcase
        for (int i = 0; i < 5; i++) tbl_us[i] = clamp_us(tbl_raw[i]);
    end

    // Signed 17-bit difference so a downward move never wraps through zero.
    always_comb begin
        all_at = 1'b1;
        for (int i = 0; i < 5; i++) begin
            diff[i] = $signed({1'b0, target[i]}) - $signed({1'b0, width[i]});
            if (diff[i] > STEP_S)
                width_nx[i] = width[i] + 16'(STEP_US);
            else if (diff[i] < -STEP_S)
                width_nx[i] = width[i] - 16'(STEP_US);
            else
                width_nx[i] = target[i];
            if (width[i] != target[i]) all_at = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        case (state)
            IDLE: if (accept) state_nx = LOAD;
            LOAD: state_nx = abort ? IDLE : RAMP;
            RAMP: begin
                if (abort)       state_nx = IDLE;
                else if (all_at) state_nx = HOLD;
            end
            HOLD: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (tick && hold_cnt == HOLD_LAST) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc         <= '0;
            hold_cnt      <= '0;
            gesture_q     <= '0;
            unknown       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            gesture_ready <= 1'b1;
            for (int i = 0; i < 5; i++) begin
                width[i]  <= RESET_US;
                target[i] <= RESET_US;
            end
        end else begin
            presc         <= tick ? '0 : presc + PW'(1);
            busy          <= (state_nx != IDLE);
            gesture_ready <= (state_nx == IDLE);
            done          <= done_nx;
            if (accept) gesture_q <= gesture;
            if (state == LOAD && !abort) begin
                unknown <= tbl_unknown;
                for (int i = 0; i < 5; i++) target[i] <= tbl_us[i];
            end
            if (state == RAMP && !abort && tick) begin
                for (int i = 0; i < 5; i++) width[i] <= width_nx[i];
            end
            if (state != HOLD)  hold_cnt <= '0;
            else if (tick)      hold_cnt <= hold_cnt + HW'(1);
        end
    end

    assign width_thumb  = width[0];
    assign width_index  = width[1];
    assign width_middle = width[2];
    assign width_ring   = width[3];
    assign width_pinky  = width[4];

endmodule

// File: tb/tb_finger_motion_sequencer.sv
// Directed bench for finger_motion_sequencer: a gesture vector table plus hand-written
// abort and mid-motion reset sequences, with a small step model for expected widths.
module tb_finger_motion_sequencer;

    localparam int TICK = 4;
    localparam int STEP = 100;
    localparam int HOLD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  gesture;
    logic        gesture_valid;
    logic        gesture_ready;
    logic        abort;
    logic [15:0] width_thumb, width_index, width_middle, width_ring, width_pinky;
    logic        busy, done, unknown;

    int n_vec = 0;
    int n_err = 0;

    finger_motion_sequencer #(
        .TICK_CYCLES(TICK), .STEP_US(STEP), .HOLD_TICKS(HOLD),
        .MIN_US(1000), .MAX_US(2000)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .gesture(gesture), .gesture_valid(gesture_valid), .gesture_ready(gesture_ready),
        .abort(abort),
        .width_thumb(width_thumb), .width_index(width_index), .width_middle(width_middle),
        .width_ring(width_ring), .width_pinky(width_pinky),
        .busy(busy), .done(done), .unknown(unknown)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        int         tgt_idx;
        int         tgt_oth;
        int         steps;
        int         unk;
    } vec_t;

    vec_t vecs [9];

    function automatic int w_of(int i);
        case (i)
            0: return int'(width_thumb);
            1: return int'(width_index);
            2: return int'(width_middle);
            3: return int'(width_ring);
            default: return int'(width_pinky);
        endcase
    endfunction

    function automatic int step_to(int w, int t);
        if (t > w) return (t - w > STEP) ? w + STEP : t;
        if (t < w) return (w - t > STEP) ? w - STEP : t;
        return w;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int c;
        c = 0;
        while (!gesture_ready && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (!gesture_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic request(input logic [7:0] code);
        wait_ready();
        @(negedge clk);
        gesture = code;
        gesture_valid = 1'b1;
        @(negedge clk);
        gesture_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int prev [5];
        int cur  [5];
        int tgt  [5];
        int last_chg, done_at, nsteps;
        bit changed;
        for (int i = 0; i < 5; i++) tgt[i] = (i == 1) ? v.tgt_idx : v.tgt_oth;
        request(v.code);
        chk($sformatf("v%0d_busy_on_accept", k), busy, 1);
        chk($sformatf("v%0d_ready_low", k), gesture_ready, 0);
        for (int i = 0; i < 5; i++) prev[i] = w_of(i);
        last_chg = -1;
        done_at  = -1;
        nsteps   = 0;
        for (int c = 0; c < 300 && done_at < 0; c++) begin
            @(negedge clk);
            changed = 1'b0;
            for (int i = 0; i < 5; i++) begin
                cur[i] = w_of(i);
                if (cur[i] != prev[i]) changed = 1'b1;
            end
            if (changed) begin
                for (int i = 0; i < 5; i++)
                    chk($sformatf("v%0d_step%0d_f%0d", k, nsteps, i), cur[i], step_to(prev[i], tgt[i]));
                if (last_chg >= 0) chk($sformatf("v%0d_tick_spacing", k), c - last_chg, TICK);
                last_chg = c;
                nsteps++;
                prev = cur;
            end
            if (done) begin
                done_at = c;
                chk($sformatf("v%0d_busy_at_done", k), busy, 0);
            end
        end
        if (done_at < 0) begin
            chk($sformatf("v%0d_done_timeout", k), 0, 1);
        end else begin
            @(negedge clk);
            chk($sformatf("v%0d_done_one_cycle", k), done, 0);
            if (nsteps > 0) chk($sformatf("v%0d_hold_len", k), done_at - last_chg, HOLD * TICK);
        end
        chk($sformatf("v%0d_steps", k), nsteps, v.steps);
        chk($sformatf("v%0d_unknown", k), unknown, v.unk);
        for (int i = 0; i < 5; i++) chk($sformatf("v%0d_final_f%0d", k, i), w_of(i), tgt[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int prev0, nchg, bad, n_d;

        vecs[0] = '{8'h01, 1500, 1500, 0,  0};
        vecs[1] = '{8'h7F, 1500, 1500, 0,  1};
        vecs[2] = '{8'h05, 1000, 2000, 5,  0};
        vecs[3] = '{8'h04, 2000, 2000, 10, 0};
        vecs[4] = '{8'h01, 1500, 1500, 5,  0};
        vecs[5] = '{8'h02, 1400, 1400, 1,  0};
        vecs[6] = '{8'h03, 1000, 1000, 4,  0};
        vecs[7] = '{8'hFF, 1500, 1500, 5,  1};
        vecs[8] = '{8'h04, 2000, 2000, 5,  0};

        rst_n = 1'b0;
        gesture = 8'h00;
        gesture_valid = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", gesture_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_unknown", unknown, 0);
        for (int i = 0; i < 5; i++) chk($sformatf("rst_w%0d", i), w_of(i), 1500);
        rst_n = 1'b1;

        // abort while idle must leave the block idle and ready
        abort = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_ready", gesture_ready, 1);
        chk("idle_abort_busy", busy, 0);

        // abort after two ticks of an open request
        request(8'h03);
        prev0 = w_of(0);
        nchg = 0;
        bad = 0;
        for (int c = 0; c < 40 && nchg < 2; c++) begin
            @(negedge clk);
            if (gesture_ready) bad++;
            if (w_of(0) != prev0) begin
                nchg++;
                prev0 = w_of(0);
            end
        end
        chk("abort_pre_changes", nchg, 2);
        chk("abort_pre_w", w_of(0), 1300);
        gesture = 8'h04;
        gesture_valid = 1'b1;
        @(negedge clk);
        if (gesture_ready) bad++;
        chk("ramp_busy", busy, 1);
        chk("ramp_ready_low", bad, 0);
        gesture_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_ready", gesture_ready, 1);
        chk("abort_done", done, 0);
        for (int i = 0; i < 5; i++) chk($sformatf("abort_w%0d", i), w_of(i), 1300);
        n_d = 0;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) n_d++;
            if (busy) bad++;
            for (int i = 0; i < 5; i++) if (w_of(i) != 1300) bad++;
        end
        chk("abort_no_done", n_d, 0);
        chk("abort_frozen", bad, 0);

        // reset pulsed in the middle of a ramp
        request(8'h04);
        prev0 = w_of(0);
        nchg = 0;
        for (int c = 0; c < 40 && nchg < 1; c++) begin
            @(negedge clk);
            if (w_of(0) != prev0) nchg++;
        end
        chk("midrst_pre_w", w_of(0), 1400);
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) chk($sformatf("midrst_w%0d", i), w_of(i), 1500);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", gesture_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 9; k++) run_vec(vecs[k], k);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
